// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings, phase codes and round-robin helpers
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  function automatic int unsigned rr_inc(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_next_dir.sv
// rtl/traffic_phase_ctrl_rr_next_dir.sv - demand arbiter: first requesting approach after cur_dir
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter int N_DIR = 4
) (
  input  logic [N_DIR-1:0]         req,
  input  logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic [$clog2(N_DIR)-1:0] next_dir,
  output logic                     any_other
);

  localparam int DW = $clog2(N_DIR);

  logic [DW-1:0] idx;

  // Walk from the farthest offset down so the nearest requester after cur_dir wins;
  // offset N_DIR lands on cur_dir itself, giving it lowest priority.
  always_comb begin
    next_dir  = DW'(rr_inc(int'(cur_dir), N_DIR));
    any_other = 1'b0;
    idx       = '0;
    for (int k = N_DIR; k >= 1; k--) begin
      idx = DW'((int'(cur_dir) + k) % N_DIR);
      if (req[idx]) next_dir = idx;
    end
    for (int i = 0; i < N_DIR; i++) begin
      if (req[i] && (DW'(i) != cur_dir)) any_other = 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - green/yellow/all-red phase sequencer with actuation and preemption
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR      = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     mode,
  input  logic [N_DIR-1:0]         req,
  input  logic                     emer,
  input  logic [$clog2(N_DIR)-1:0] emer_dir,
  output logic [3*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic [1:0]               phase
);

  localparam int DW = $clog2(N_DIR);
  localparam int CW = $clog2(max3(GREEN_CYC, YELLOW_CYC, ALLRED_CYC) + 1);
  localparam logic [CW-1:0] G_LAST = CW'(GREEN_CYC - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] A_LAST = CW'(ALLRED_CYC - 1);

  phase_e             phase_q, phase_d;
  logic [DW-1:0]      dir_q, dir_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3*N_DIR-1:0] lights_q, lights_d;
  logic [DW-1:0]      rr_dir;
  logic               any_other;
  logic               emer_v;
  logic               g_done;

  rr_next_dir #(.N_DIR(N_DIR)) u_rr (
    .req       (req),
    .cur_dir   (dir_q),
    .next_dir  (rr_dir),
    .any_other (any_other)
  );

  assign emer_v = emer && (int'(emer_dir) < N_DIR);
  assign g_done = (cnt_q >= G_LAST);

  // The green counter saturates at G_LAST so a held green resumes with dwell already met.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (phase_q)
      PH_GREEN: begin
        if (!g_done) cnt_d = cnt_q + 1'b1;
        if (emer_v && (emer_dir != dir_q)) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end else if (!emer_v && g_done && (!mode || any_other)) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end
      end
      PH_YELLOW: begin
        if (cnt_q == Y_LAST) begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (cnt_q == A_LAST) begin
          phase_d = PH_GREEN;
          cnt_d   = '0;
          if (emer_v)    dir_d = emer_dir;
          else if (mode) dir_d = rr_dir;
          else           dir_d = DW'(rr_inc(int'(dir_q), N_DIR));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lights_d = '0;
    for (int i = 0; i < N_DIR; i++) begin
      if ((phase_d == PH_GREEN) && (dir_d == DW'(i)))       lights_d[3*i +: 3] = LIGHT_GREEN;
      else if ((phase_d == PH_YELLOW) && (dir_d == DW'(i))) lights_d[3*i +: 3] = LIGHT_YELLOW;
      else                                                  lights_d[3*i +: 3] = LIGHT_RED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      phase_q  <= PH_GREEN;
      dir_q    <= '0;
      cnt_q    <= '0;
      lights_q <= {{(N_DIR-1){LIGHT_RED}}, LIGHT_GREEN};
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
    end
  end

  assign lights  = lights_q;
  assign cur_dir = dir_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  req = 4'b0;
  logic        emer = 1'b0;
  logic [1:0]  emer_dir = 2'd0;
  logic [11:0] lights;
  logic [1:0]  cur_dir;
  logic [1:0]  phase;

  logic        rst3 = 1'b0;
  logic        mode3 = 1'b0;
  logic [2:0]  req3 = 3'b101;
  logic        emer3 = 1'b1;
  logic [1:0]  emer_dir3 = 2'd3;
  logic [8:0]  lights3;
  logic [1:0]  cur_dir3;
  logic [1:0]  phase3;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl dut (
    .clk(clk), .rst_a(rst_a), .mode(mode), .req(req), .emer(emer), .emer_dir(emer_dir),
    .lights(lights), .cur_dir(cur_dir), .phase(phase)
  );

  traffic_phase_ctrl #(.N_DIR(3), .GREEN_CYC(2), .YELLOW_CYC(4), .ALLRED_CYC(1)) dut3 (
    .clk(clk), .rst_a(rst3), .mode(mode3), .req(req3), .emer(emer3), .emer_dir(emer_dir3),
    .lights(lights3), .cur_dir(cur_dir3), .phase(phase3)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_a = 1'b0;
    tick();
    tick();
    rst_a = 1'b1;
  endtask

  function automatic logic [11:0] exp_l4(input logic [1:0] ph, input logic [1:0] d);
    logic [11:0] r;
    r = {4{3'b100}};
    if (ph == 2'b00)      r[3*d +: 3] = 3'b001;
    else if (ph == 2'b01) r[3*d +: 3] = 3'b010;
    return r;
  endfunction

  function automatic logic [8:0] exp_l3(input logic [1:0] ph, input logic [1:0] d);
    logic [8:0] r;
    r = {3{3'b100}};
    if (ph == 2'b00)      r[3*d +: 3] = 3'b001;
    else if (ph == 2'b01) r[3*d +: 3] = 3'b010;
    return r;
  endfunction

  function automatic int nonred(input logic [23:0] l, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b100) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({phase, cur_dir, lights} !== {2'b00, 2'd0, 12'b100_100_100_001}) begin
        errors++;
        $display("FAIL reset_state: got ph=%b dir=%0d lights=%b, want ph=00 dir=0 lights=100100100001",
                 phase, cur_dir, lights);
      end
    end
    rst_a = 1'b1;
  endtask

  task automatic test_fixed_cycle();
    logic [1:0] eph, ed;
    int p;
    mode = 1'b0; req = 4'b0; emer = 1'b0;
    do_reset();
    for (int t = 0; t <= 52; t++) begin
      ed  = 2'((t / 13) % 4);
      p   = t % 13;
      eph = (p < 8) ? 2'b00 : (p < 12) ? 2'b01 : 2'b10;
      checks++;
      if ({phase, cur_dir, lights} !== {eph, ed, exp_l4(eph, ed)}) begin
        errors++;
        $display("FAIL fixed_cycle t=%0d: got ph=%b dir=%0d lights=%b, want ph=%b dir=%0d lights=%b",
                 t, phase, cur_dir, lights, eph, ed, exp_l4(eph, ed));
      end
      checks++;
      if (nonred({12'b0, lights}, 4) > 1) begin
        errors++;
        $display("FAIL fixed_onehot t=%0d: got lights=%b, want at most one non-red", t, lights);
      end
      tick();
    end
  endtask

  task automatic test_actuated_hold();
    logic [1:0] eph, ed;
    mode = 1'b1; req = 4'b0; emer = 1'b0;
    do_reset();
    for (int t = 0; t < 100; t++) begin
      if (t == 50) req = 4'b0001;
      checks++;
      if ({phase, cur_dir} !== {2'b00, 2'd0}) begin
        errors++;
        $display("FAIL actuated_hold t=%0d: got ph=%b dir=%0d, want ph=00 dir=0", t, phase, cur_dir);
      end
      tick();
    end
    req = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      eph = (k <= 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
      ed  = (k == 6) ? 2'd2 : 2'd0;
      checks++;
      if ({phase, cur_dir, lights} !== {eph, ed, exp_l4(eph, ed)}) begin
        errors++;
        $display("FAIL actuated_release k=%0d: got ph=%b dir=%0d lights=%b, want ph=%b dir=%0d",
                 k, phase, cur_dir, lights, eph, ed);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_rr_arbitration();
    logic [1:0] eph, ed;
    logic [1:0] seq [4];
    int p;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;
    mode = 1'b1; req = 4'b1011; emer = 1'b0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      ed  = seq[t / 13];
      p   = t % 13;
      eph = (p < 8) ? 2'b00 : (p < 12) ? 2'b01 : 2'b10;
      checks++;
      if ({phase, cur_dir} !== {eph, ed}) begin
        errors++;
        $display("FAIL rr_arbitration t=%0d: got ph=%b dir=%0d, want ph=%b dir=%0d",
                 t, phase, cur_dir, eph, ed);
      end
      tick();
    end
    req = 4'b0;
  endtask

  task automatic test_preemption();
    logic [1:0] eph, ed;
    mode = 1'b0; req = 4'b0; emer = 1'b0;
    do_reset();
    for (int t = 0; t < 28; t++) tick();
    checks++;
    if ({phase, cur_dir} !== {2'b00, 2'd2}) begin
      errors++;
      $display("FAIL emer_setup: got ph=%b dir=%0d, want ph=00 dir=2", phase, cur_dir);
    end
    emer = 1'b1; emer_dir = 2'd3;
    for (int k = 1; k <= 36; k++) begin
      tick();
      eph = (k <= 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
      ed  = (k <= 5) ? 2'd2 : 2'd3;
      checks++;
      if ({phase, cur_dir, lights} !== {eph, ed, exp_l4(eph, ed)}) begin
        errors++;
        $display("FAIL emer_sequence k=%0d: got ph=%b dir=%0d lights=%b, want ph=%b dir=%0d",
                 k, phase, cur_dir, lights, eph, ed);
      end
    end
    emer = 1'b0;
    tick();
    checks++;
    if ({phase, cur_dir} !== {2'b01, 2'd3}) begin
      errors++;
      $display("FAIL emer_release: got ph=%b dir=%0d, want ph=01 dir=3", phase, cur_dir);
    end
    emer_dir = 2'd0;
  endtask

  task automatic test_reset_mid_yellow();
    mode = 1'b0; req = 4'b0; emer = 1'b0;
    do_reset();
    for (int t = 0; t < 22; t++) tick();
    checks++;
    if ({phase, cur_dir} !== {2'b01, 2'd1}) begin
      errors++;
      $display("FAIL midreset_setup: got ph=%b dir=%0d, want ph=01 dir=1", phase, cur_dir);
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if ({phase, cur_dir, lights} !== {2'b00, 2'd0, 12'b100_100_100_001}) begin
      errors++;
      $display("FAIL midreset_state: got ph=%b dir=%0d lights=%b, want ph=00 dir=0 lights=100100100001",
               phase, cur_dir, lights);
    end
    rst_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (phase !== ((k < 8) ? 2'b00 : 2'b01) || cur_dir !== 2'd0) begin
        errors++;
        $display("FAIL midreset_dwell k=%0d: got ph=%b dir=%0d, want ph=%b dir=0",
                 k, phase, cur_dir, (k < 8) ? 2'b00 : 2'b01);
      end
    end
  endtask

  task automatic test_wrap_three_dir();
    logic [1:0] eph, ed;
    int p;
    rst3 = 1'b0;
    tick();
    tick();
    rst3 = 1'b1;
    for (int t = 0; t < 28; t++) begin
      ed  = 2'((t / 7) % 3);
      p   = t % 7;
      eph = (p < 2) ? 2'b00 : (p < 6) ? 2'b01 : 2'b10;
      checks++;
      if ({phase3, cur_dir3, lights3} !== {eph, ed, exp_l3(eph, ed)}) begin
        errors++;
        $display("FAIL wrap3 t=%0d: got ph=%b dir=%0d lights=%b, want ph=%b dir=%0d lights=%b",
                 t, phase3, cur_dir3, lights3, eph, ed, exp_l3(eph, ed));
      end
      checks++;
      if (nonred({15'b0, lights3}, 3) > 1) begin
        errors++;
        $display("FAIL wrap3_onehot t=%0d: got lights=%b, want at most one non-red", t, lights3);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fixed_cycle();
    test_actuated_hold();
    test_rr_arbitration();
    test_preemption();
    test_reset_mid_yellow();
    test_wrap_three_dir();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
